// File: rtl/ft_small_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ftfifo_pkg
// Brief    : Shared types and sizing helpers for the ft_small_fifo block.
// Revision : 1.0 - initial release
// ============================================================================
package ftfifo_pkg;

    // Status flags, all decoded from the registered occupancy count.
    typedef struct packed {
        logic full;
        logic nearly_full;
        logic prog_full;
        logic empty;
    } ftfifo_flags_t;

    // Ceiling log2; returns 1 for inputs of 0 or 1 so a pointer is never zero-width.
    function automatic int unsigned ftfifo_log2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Number of storage words for a given pointer width.
    function automatic int unsigned ftfifo_depth(input int unsigned depth_bits);
        return 1 << depth_bits;
    endfunction

    // Occupancy counter width: one extra bit so the value DEPTH is representable.
    function automatic int unsigned ftfifo_cnt_width(input int unsigned depth_bits);
        return depth_bits + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_small_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : ft_small_fifo_if
// Brief    : Write/read handshake and status bundle for ft_small_fifo.
//            master = producer/consumer side, slave = the FIFO itself.
// Revision : 1.0 - initial release
// ============================================================================
interface ft_small_fifo_if #(
    parameter int WIDTH = 72
);
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             nearly_full;
    logic             prog_full;
    logic             empty;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, nearly_full, prog_full, empty
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, nearly_full, prog_full, empty
    );
endinterface
`default_nettype wire

// File: rtl/ft_small_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ftfifo_ctrl
// Brief    : Pointer, occupancy count and flag logic for ft_small_fifo.
//            Full is evaluated before the pop, so a write into a full FIFO is
//            dropped even when a read happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ftfifo_ctrl
    import ftfifo_pkg::*;
#(
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = (2**MAX_DEPTH_BITS) - 1,
    parameter int PTR_W               = ftfifo_log2(ftfifo_depth(MAX_DEPTH_BITS))
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_wr_en,
    input  wire logic             i_rd_en,
    output logic                  o_push,
    output logic [PTR_W-1:0]      o_wr_ptr,
    output logic [PTR_W-1:0]      o_rd_ptr,
    output ftfifo_flags_t         o_flags
);
    localparam int unsigned c_DEPTH = ftfifo_depth(MAX_DEPTH_BITS);
    localparam int unsigned c_CNT_W = ftfifo_cnt_width(MAX_DEPTH_BITS);

    localparam logic [PTR_W-1:0]   c_PTR_ONE = PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL_LV = c_CNT_W'(c_DEPTH);
    localparam logic [c_CNT_W-1:0] c_NFUL_LV = c_CNT_W'(c_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_PROG_LV = c_CNT_W'(PROG_FULL_THRESHOLD);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Flags decode directly from the registered count.
    always_comb begin
        o_flags             = '0;
        o_flags.full        = (r_count == c_FULL_LV);
        o_flags.nearly_full = (r_count >= c_NFUL_LV);
        o_flags.prog_full   = (r_count >= c_PROG_LV);
        o_flags.empty       = (r_count == '0);
    end

    assign w_push   = i_wr_en && !o_flags.full;
    assign w_pop    = i_rd_en && !o_flags.empty;
    assign o_push   = w_push;
    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;

    // Pointers wrap naturally at DEPTH; count tracks accepted pushes minus pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ft_small_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ft_small_fifo
// Brief    : Small first-word-fall-through FIFO; head word is on dout
//            whenever empty is low, rd_en acknowledges (pops) it.
//            Optional macro FTFIFO_DOUT_ZERO_EN forces dout to zero while
//            empty; otherwise dout shows the (stale) word at the read pointer.
// Revision : 1.0 - initial release
// ============================================================================
module ft_small_fifo
    import ftfifo_pkg::*;
#(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = (2**MAX_DEPTH_BITS) - 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ft_small_fifo_if.slave  fifo
);
    localparam int unsigned c_DEPTH = ftfifo_depth(MAX_DEPTH_BITS);
    localparam int unsigned c_PTR_W = ftfifo_log2(c_DEPTH);

    logic [WIDTH-1:0]   r_mem [c_DEPTH];
    logic               w_push;
    logic [c_PTR_W-1:0] w_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;
    ftfifo_flags_t      w_flags;
    logic [WIDTH-1:0]   w_head;

    ftfifo_ctrl #(
        .MAX_DEPTH_BITS      (MAX_DEPTH_BITS),
        .PROG_FULL_THRESHOLD (PROG_FULL_THRESHOLD),
        .PTR_W               (c_PTR_W)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (fifo.wr_en),
        .i_rd_en  (fifo.rd_en),
        .o_push   (w_push),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_flags  (w_flags)
    );

    // Storage write; contents are intentionally left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= fifo.din;
        end
    end

    assign w_head = r_mem[w_rd_ptr];

`ifdef FTFIFO_DOUT_ZERO_EN
    assign fifo.dout = w_flags.empty ? '0 : w_head;
`else
    assign fifo.dout = w_head;
`endif

    assign fifo.full        = w_flags.full;
    assign fifo.nearly_full = w_flags.nearly_full;
    assign fifo.prog_full   = w_flags.prog_full;
    assign fifo.empty       = w_flags.empty;

`ifndef SYNTHESIS
    // Simulation-only notice when a request is discarded.
    always @(posedge clk) begin
        if (!reset && fifo.wr_en && w_flags.full) begin
            $display("ft_small_fifo: warning: write dropped while full at %0t", $time);
        end
        if (!reset && fifo.rd_en && w_flags.empty) begin
            $display("ft_small_fifo: warning: read ignored while empty at %0t", $time);
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_ft_small_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft_small_fifo
// Brief    : Directed self-checking bench for ft_small_fifo (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft_small_fifo;
    localparam int c_WIDTH = 72;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ft_small_fifo_if #(.WIDTH(c_WIDTH)) bus ();

    ft_small_fifo #(
        .WIDTH               (c_WIDTH),
        .MAX_DEPTH_BITS      (3),
        .PROG_FULL_THRESHOLD (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus.slave)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_value(input string tag, input logic [c_WIDTH-1:0] got,
                               input logic [c_WIDTH-1:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic e, input logic f,
                               input logic nf, input logic pf);
        check_value({tag, ".empty"},       c_WIDTH'(bus.empty),       c_WIDTH'(e));
        check_value({tag, ".full"},        c_WIDTH'(bus.full),        c_WIDTH'(f));
        check_value({tag, ".nearly_full"}, c_WIDTH'(bus.nearly_full), c_WIDTH'(nf));
        check_value({tag, ".prog_full"},   c_WIDTH'(bus.prog_full),   c_WIDTH'(pf));
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.din   = 72'hEE;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;

        // Reset with wr_en held high.
        step();
        step();
        check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FTFIFO_DOUT_ZERO_EN
        check_value("reset.dout", bus.dout, '0);
`endif
        idle();
        reset = 1'b0;
        step();
        check_flags("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // Single word fall-through.
        bus.din = 72'hA1; bus.wr_en = 1'b1;
        step();
        idle();
        check_flags("a1_push", 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("a1_dout", bus.dout, 72'hA1);
        step();
        check_value("a1_hold", bus.dout, 72'hA1);
        bus.rd_en = 1'b1;
        step();
        idle();
        check_flags("a1_pop", 1'b1, 1'b0, 1'b0, 1'b0);

        // Read on empty does nothing.
        bus.rd_en = 1'b1;
        step();
        idle();
        check_flags("rd_empty", 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill 1..8, watching thresholds.
        for (int i = 1; i <= 8; i++) begin
            bus.din = c_WIDTH'(i); bus.wr_en = 1'b1;
            step();
            check_flags($sformatf("fill%0d", i), 1'b0, (i == 8), (i >= 7), (i >= 7));
            check_value($sformatf("fill%0d.dout", i), bus.dout, 72'd1);
        end
        bus.din = 72'h99;
        step();
        idle();
        check_flags("drop99", 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            check_value($sformatf("drain%0d", i), bus.dout, c_WIDTH'(i));
            bus.rd_en = 1'b1;
            step();
        end
        idle();
        check_flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);

        // Full with simultaneous write and read: read wins, write dropped.
        for (int i = 1; i <= 8; i++) begin
            bus.din = c_WIDTH'(8'h10 + i); bus.wr_en = 1'b1;
            step();
        end
        check_flags("refill", 1'b0, 1'b1, 1'b1, 1'b1);
        bus.din = 72'h55; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        step();
        idle();
        check_flags("full_rw", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            check_value($sformatf("no55_%0d", i), bus.dout, c_WIDTH'(8'h10 + i));
            bus.rd_en = 1'b1;
            step();
        end
        idle();
        check_flags("no55_end", 1'b1, 1'b0, 1'b0, 1'b0);

        // Empty with simultaneous write and read: write wins.
        bus.din = 72'h33; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        step();
        idle();
        check_flags("empty_rw", 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("empty_rw.dout", bus.dout, 72'h33);
        bus.rd_en = 1'b1;
        step();
        idle();
        check_flags("empty_rw_pop", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FTFIFO_DOUT_ZERO_EN
        check_value("empty_rw_pop.dout", bus.dout, '0);
`endif

        // Steady streaming at occupancy 3 across the pointer wrap.
        for (int k = 0; k < 3; k++) begin
            bus.din = c_WIDTH'(12'h100 + k); bus.wr_en = 1'b1;
            step();
        end
        for (int j = 0; j < 20; j++) begin
            check_value($sformatf("stream%0d", j), bus.dout, c_WIDTH'(12'h100 + j));
            bus.din = c_WIDTH'(12'h103 + j); bus.wr_en = 1'b1; bus.rd_en = 1'b1;
            step();
            check_flags($sformatf("stream%0d", j), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        for (int j = 20; j < 23; j++) begin
            check_value($sformatf("tail%0d", j), bus.dout, c_WIDTH'(12'h100 + j));
            bus.rd_en = 1'b1;
            step();
        end
        idle();
        check_flags("tail_end", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FTFIFO_DOUT_ZERO_EN
        check_value("tail_end.dout", bus.dout, '0);
`endif

        // Reset in the middle of traffic discards contents.
        bus.din = 72'h77; bus.wr_en = 1'b1;
        step();
        step();
        check_flags("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; bus.rd_en = 1'b1;
        step();
        check_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        reset = 1'b0;
        step();
        check_flags("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
